// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator cabin slice: state-word and request bit
// positions, floor codes and the cabin FSM encoding.
package elevator_pkg;

  localparam int ST_MOVING    = 3;
  localparam int ST_DIR_UP    = 2;
  localparam int ST_FLOOR_MSB = 1;
  localparam int ST_FLOOR_LSB = 0;

  localparam logic [1:0] FLOOR_1 = 2'd0;
  localparam logic [1:0] FLOOR_2 = 2'd1;
  localparam logic [1:0] FLOOR_3 = 2'd2;
  localparam logic [1:0] FLOOR_4 = 2'd3;

  localparam int REQ_W      = 10;
  localparam int REQ_F1_UP  = 0;
  localparam int REQ_F2_DN  = 1;
  localparam int REQ_F2_UP  = 2;
  localparam int REQ_F3_DN  = 3;
  localparam int REQ_F3_UP  = 4;
  localparam int REQ_F4_DN  = 5;
  localparam int REQ_CAB_F1 = 6;
  localparam int REQ_CAB_F2 = 7;
  localparam int REQ_CAB_F3 = 8;
  localparam int REQ_CAB_F4 = 9;

  typedef enum logic [2:0] {
    CAB_IDLE,
    CAB_TRAVEL,
    CAB_OPENING,
    CAB_OPEN,
    CAB_CLOSING
  } cabin_state_t;

endpackage

// File: rtl/elevator_cabin_if.sv
// Dispatcher <-> cabin signal bundle. The obstruccion beam input exists only
// when ELEVATOR_DOOR_OBSTRUCT_EN is defined.
interface elevator_cabin_if;
  import elevator_pkg::*;

  logic [3:0]       estado;
  logic [REQ_W-1:0] s;
  logic             cambio_piso;
  logic             esperar;
  logic             puerta_abierta;
  logic [REQ_W-1:0] atendido;
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
  logic             obstruccion;

  modport master (output estado, s, obstruccion,
                  input  cambio_piso, esperar, puerta_abierta, atendido);
  modport slave  (input  estado, s, obstruccion,
                  output cambio_piso, esperar, puerta_abierta, atendido);
`else
  modport master (output estado, s,
                  input  cambio_piso, esperar, puerta_abierta, atendido);
  modport slave  (input  estado, s,
                  output cambio_piso, esperar, puerta_abierta, atendido);
`endif
endinterface

// File: rtl/elevator_door_fsm.sv
// Cabin state sequencing (idle/travel/door cycle) with the shared door timer.
// Obstruction re-open is compiled in with ELEVATOR_DOOR_OBSTRUCT_EN.
module elevator_door_fsm
  import elevator_pkg::*;
#(
  parameter int DOOR_MOVE_CYCLES = 10,
  parameter int DOOR_OPEN_CYCLES = 100,
  parameter int CNT_W            = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         moving,
  input  logic         hit,
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
  input  logic         obstruccion,
`endif
  output cabin_state_t state,
  output logic         open_entry,
  output logic         esperar,
  output logic         puerta_abierta
);

  cabin_state_t     nxt;
  logic [CNT_W-1:0] dcnt, dcnt_nxt;
  logic             obstruct;

`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
  assign obstruct = obstruccion;
`else
  assign obstruct = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CAB_IDLE;
      dcnt           <= '0;
      esperar        <= 1'b0;
      puerta_abierta <= 1'b0;
    end else begin
      state          <= nxt;
      dcnt           <= dcnt_nxt;
      esperar        <= (nxt == CAB_OPENING) || (nxt == CAB_OPEN) || (nxt == CAB_CLOSING);
      puerta_abierta <= (nxt == CAB_OPEN);
    end
  end

  // Only the OPENING->OPEN edge raises open_entry, so an obstruction re-open never re-serves.
  always_comb begin
    nxt        = state;
    dcnt_nxt   = dcnt;
    open_entry = 1'b0;
    case (state)
      CAB_IDLE: begin
        if (moving) begin
          nxt = CAB_TRAVEL;
        end else if (hit) begin
          nxt      = CAB_OPENING;
          dcnt_nxt = '0;
        end
      end
      CAB_TRAVEL: begin
        if (!moving) begin
          nxt      = CAB_OPENING;
          dcnt_nxt = '0;
        end
      end
      CAB_OPENING: begin
        if (dcnt == CNT_W'(DOOR_MOVE_CYCLES - 1)) begin
          nxt        = CAB_OPEN;
          dcnt_nxt   = '0;
          open_entry = 1'b1;
        end else begin
          dcnt_nxt = dcnt + CNT_W'(1);
        end
      end
      CAB_OPEN: begin
        if (obstruct) begin
          dcnt_nxt = '0;
        end else if (dcnt == CNT_W'(DOOR_OPEN_CYCLES - 1)) begin
          nxt      = CAB_CLOSING;
          dcnt_nxt = '0;
        end else begin
          dcnt_nxt = dcnt + CNT_W'(1);
        end
      end
      CAB_CLOSING: begin
        if (obstruct) begin
          nxt      = CAB_OPEN;
          dcnt_nxt = '0;
        end else if (dcnt == CNT_W'(DOOR_MOVE_CYCLES - 1)) begin
          nxt      = CAB_IDLE;
          dcnt_nxt = '0;
        end else begin
          dcnt_nxt = dcnt + CNT_W'(1);
        end
      end
      default: begin
        nxt      = CAB_IDLE;
        dcnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/elevator_cabin.sv
// Cabin/door side of the elevator loop: floor-crossing toggle, door hold and
// served-request clear pulses. Optional macro: ELEVATOR_DOOR_OBSTRUCT_EN.
module elevator_cabin
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES    = 50,
  parameter int DOOR_MOVE_CYCLES = 10,
  parameter int DOOR_OPEN_CYCLES = 100
) (
  input  logic             clk,
  input  logic             reset,
  elevator_cabin_if.slave  bus
);

  localparam int MAX_A      = (TRAVEL_CYCLES > DOOR_MOVE_CYCLES) ? TRAVEL_CYCLES : DOOR_MOVE_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > DOOR_OPEN_CYCLES) ? MAX_A : DOOR_OPEN_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  // Requests cleared when the doors open at floor fl travelling in direction up.
  function automatic logic [REQ_W-1:0] serve_mask(input logic [1:0] fl, input logic up);
    logic [REQ_W-1:0] m;
    m = '0;
    case (fl)
      FLOOR_1: begin
        m[REQ_CAB_F1] = 1'b1;
        m[REQ_F1_UP]  = 1'b1;
      end
      FLOOR_2: begin
        m[REQ_CAB_F2] = 1'b1;
        if (up) m[REQ_F2_UP] = 1'b1;
        else    m[REQ_F2_DN] = 1'b1;
      end
      FLOOR_3: begin
        m[REQ_CAB_F3] = 1'b1;
        if (up) m[REQ_F3_UP] = 1'b1;
        else    m[REQ_F3_DN] = 1'b1;
      end
      default: begin
        m[REQ_CAB_F4] = 1'b1;
        m[REQ_F4_DN]  = 1'b1;
      end
    endcase
    return m;
  endfunction

  logic [1:0]       floor;
  logic             up, moving, hit;
  cabin_state_t     state;
  logic             open_entry, esperar, puerta_abierta;
  logic [CNT_W-1:0] tcnt;
  logic             cambio_piso;
  logic [REQ_W-1:0] atendido;

  assign floor  = bus.estado[ST_FLOOR_MSB:ST_FLOOR_LSB];
  assign up     = bus.estado[ST_DIR_UP];
  assign moving = bus.estado[ST_MOVING];
  assign hit    = |((serve_mask(floor, 1'b1) | serve_mask(floor, 1'b0)) & bus.s);

  elevator_door_fsm #(
    .DOOR_MOVE_CYCLES (DOOR_MOVE_CYCLES),
    .DOOR_OPEN_CYCLES (DOOR_OPEN_CYCLES),
    .CNT_W            (CNT_W)
  ) u_door (
    .clk            (clk),
    .reset          (reset),
    .moving         (moving),
    .hit            (hit),
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    .obstruccion    (bus.obstruccion),
`endif
    .state          (state),
    .open_entry     (open_entry),
    .esperar        (esperar),
    .puerta_abierta (puerta_abierta)
  );

  // Travel counter restarts from 0 whenever travel is (re)entered or abandoned.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt        <= '0;
      cambio_piso <= 1'b0;
      atendido    <= '0;
    end else begin
      atendido <= open_entry ? (serve_mask(floor, up) & bus.s) : '0;
      if ((state == CAB_TRAVEL) && moving) begin
        if (tcnt == CNT_W'(TRAVEL_CYCLES - 1)) begin
          tcnt        <= '0;
          cambio_piso <= ~cambio_piso;
        end else begin
          tcnt <= tcnt + CNT_W'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  assign bus.cambio_piso    = cambio_piso;
  assign bus.esperar        = esperar;
  assign bus.puerta_abierta = puerta_abierta;
  assign bus.atendido       = atendido;

endmodule

// File: tb/tb_elevator_cabin.sv
// Self-checking bench for elevator_cabin: directed scenarios plus randomized
// traffic compared against a timeline-based reference model.
module tb_elevator_cabin;

  localparam int T = 4;
  localparam int M = 2;
  localparam int O = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  elevator_cabin_if bus();

  elevator_cabin #(
    .TRAVEL_CYCLES    (T),
    .DOOR_MOVE_CYCLES (M),
    .DOOR_OPEN_CYCLES (O)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 travel, 2 door cycle tracked as one timeline 0..2M+O-1.
  int         m_mode, m_n, m_t;
  logic       m_cp, m_esp, m_pa;
  logic [9:0] m_at;

  function automatic logic [9:0] model_served(input logic [1:0] f, input logic up, input logic [9:0] req);
    logic [9:0] m;
    int fi;
    fi = int'(f);
    m = '0;
    m[6 + fi] = 1'b1;
    if (fi == 0)      m[0] = 1'b1;
    else if (fi == 3) m[5] = 1'b1;
    else if (up)      m[2 * fi] = 1'b1;
    else              m[2 * fi - 1] = 1'b1;
    return m & req;
  endfunction

  function automatic logic model_hit(input logic [1:0] f, input logic [9:0] req);
    logic h;
    int fi;
    fi = int'(f);
    h = req[6 + fi];
    if (fi < 3) h = h | req[2 * fi];
    if (fi > 0) h = h | req[2 * fi - 1];
    return h;
  endfunction

  always @(posedge clk) begin : model
    logic obs;
    int   nt;
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    obs = bus.obstruccion;
`else
    obs = 1'b0;
`endif
    if (reset) begin
      m_mode <= 0; m_n <= 0; m_t <= 0;
      m_cp <= 1'b0; m_esp <= 1'b0; m_pa <= 1'b0; m_at <= '0;
    end else begin
      m_at <= '0;
      case (m_mode)
        0: begin
          if (bus.estado[3]) begin
            m_mode <= 1; m_n <= 0;
          end else if (model_hit(bus.estado[1:0], bus.s)) begin
            m_mode <= 2; m_t <= 0; m_esp <= 1'b1;
          end
        end
        1: begin
          if (!bus.estado[3]) begin
            m_mode <= 2; m_t <= 0; m_esp <= 1'b1;
          end else begin
            if (m_n % T == T - 1) m_cp <= ~m_cp;
            m_n <= m_n + 1;
          end
        end
        default: begin
          nt = m_t + 1;
          if (obs && m_t >= M) nt = M;
          else if (nt == M) m_at <= model_served(bus.estado[1:0], bus.estado[2], bus.s);
          if (nt == 2 * M + O) begin
            m_mode <= 0; m_esp <= 1'b0; m_pa <= 1'b0;
          end else begin
            m_t <= nt; m_pa <= (nt >= M) && (nt < M + O);
          end
        end
      endcase
    end
  end

  // One clock; the request latch is emulated by clearing whatever was just served.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    bus.s = bus.s & ~bus.atendido;
  endtask

  task automatic run_door(output int esp_n, output int at_n, output logic [9:0] at_v,
                          output logic at_open, output int pa_n, output bit timeout);
    bit seen;
    seen = 0; esp_n = 0; at_n = 0; at_v = '0; at_open = 1'b0; pa_n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (bus.esperar) begin esp_n++; seen = 1; end
      if (bus.puerta_abierta) pa_n++;
      if (bus.atendido != '0) begin at_n++; at_v = bus.atendido; at_open = bus.puerta_abierta; end
      if (seen && !bus.esperar) break;
    end
    timeout = !(seen && !bus.esperar);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.estado = 4'b0000;
    bus.s = '0;
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    bus.obstruccion = 1'b0;
`endif
    cyc(); cyc();
    checks++; if (bus.cambio_piso !== 1'b0) begin errors++; $display("FAIL reset_cambio: got %b expected 0", bus.cambio_piso); end
    checks++; if (bus.esperar !== 1'b0) begin errors++; $display("FAIL reset_esperar: got %b expected 0", bus.esperar); end
    checks++; if (bus.puerta_abierta !== 1'b0) begin errors++; $display("FAIL reset_puerta: got %b expected 0", bus.puerta_abierta); end
    checks++; if (bus.atendido !== 10'h000) begin errors++; $display("FAIL reset_atendido: got %h expected 000", bus.atendido); end
  endtask

  task automatic test_travel();
    int   toggles, esp_hi, first_idx, last_idx, bad_gap;
    logic prev;
    reset = 1'b1;
    bus.estado = 4'b1100;
    cyc();
    reset = 1'b0;
    prev = bus.cambio_piso;
    toggles = 0; esp_hi = 0; first_idx = 0; last_idx = 0; bad_gap = 0;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      if (bus.esperar) esp_hi++;
      if (bus.cambio_piso !== prev) begin
        toggles++;
        if (toggles == 1) first_idx = i;
        else if (i - last_idx != T) bad_gap++;
        last_idx = i;
        prev = bus.cambio_piso;
      end
    end
    checks++; if (toggles != 3) begin errors++; $display("FAIL travel_toggles: got %0d expected 3", toggles); end
    checks++; if (first_idx != T + 1) begin errors++; $display("FAIL travel_first: got cycle %0d expected %0d", first_idx, T + 1); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL travel_spacing: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (esp_hi != 0) begin errors++; $display("FAIL travel_esperar: got %0d high cycles expected 0", esp_hi); end
  endtask

  task automatic test_door_up();
    int esp_n, at_n, pa_n; logic [9:0] at_v; logic at_open; bit to;
    bus.estado = 4'b0101;
    bus.s = 10'h084;
    run_door(esp_n, at_n, at_v, at_open, pa_n, to);
    checks++; if (to) begin errors++; $display("FAIL up_timeout: door cycle did not finish"); end
    checks++; if (esp_n != 2 * M + O) begin errors++; $display("FAIL up_esperar: got %0d expected %0d", esp_n, 2 * M + O); end
    checks++; if (at_n != 1 || at_v !== 10'h084) begin errors++; $display("FAIL up_atendido: got %0d pulses value %h expected 1 x 084", at_n, at_v); end
    checks++; if (at_open !== 1'b1) begin errors++; $display("FAIL up_at_open: got puerta %b at pulse expected 1", at_open); end
    checks++; if (pa_n != O) begin errors++; $display("FAIL up_puerta: got %0d expected %0d", pa_n, O); end
  endtask

  task automatic test_door_down();
    int esp_n, at_n, pa_n; logic [9:0] at_v; logic at_open; bit to;
    bus.estado = 4'b0001;
    bus.s = 10'h006;
    run_door(esp_n, at_n, at_v, at_open, pa_n, to);
    checks++; if (to || esp_n != 2 * M + O) begin errors++; $display("FAIL down_esperar: got %0d timeout %0d expected %0d", esp_n, to, 2 * M + O); end
    checks++; if (at_n != 1 || at_v !== 10'h002) begin errors++; $display("FAIL down_atendido: got %0d pulses value %h expected 1 x 002", at_n, at_v); end
    checks++; if (bus.s !== 10'h004) begin errors++; $display("FAIL down_pending: got s=%h expected 004", bus.s); end
    bus.s = '0;
  endtask

  task automatic test_idle_f1();
    int esp_n, at_n, pa_n; logic [9:0] at_v; logic at_open; bit to;
    bus.estado = 4'b0000;
    bus.s = 10'h001;
    run_door(esp_n, at_n, at_v, at_open, pa_n, to);
    checks++; if (to || esp_n != 2 * M + O) begin errors++; $display("FAIL f1_esperar: got %0d timeout %0d expected %0d", esp_n, to, 2 * M + O); end
    checks++; if (at_n != 1 || at_v !== 10'h001) begin errors++; $display("FAIL f1_atendido: got %0d pulses value %h expected 1 x 001", at_n, at_v); end
  endtask

  task automatic test_reset_mid();
    int   cp_changes, esp_hi;
    bit   found;
    logic cp0;
    bus.estado = 4'b0000;
    bus.s = 10'h040;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(); if (bus.puerta_abierta) found = 1; end
    checks++; if (!found) begin errors++; $display("FAIL rmid_open: got no OPEN expected OPEN within 20 cycles"); end
    reset = 1'b1;
    cyc();
    checks++; if ({bus.cambio_piso, bus.esperar, bus.puerta_abierta} !== 3'b000 || bus.atendido !== '0)
      begin errors++; $display("FAIL rmid_outputs: got cp/esp/pa=%b%b%b at=%h expected all 0", bus.cambio_piso, bus.esperar, bus.puerta_abierta, bus.atendido); end
    reset = 1'b0;
    bus.s = '0;
    esp_hi = 0;
    for (int i = 0; i < 3; i++) begin cyc(); if (bus.esperar) esp_hi++; end
    checks++; if (esp_hi != 0) begin errors++; $display("FAIL rmid_idle: got %0d esperar cycles expected 0", esp_hi); end
    bus.s = 10'h040;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(); if (bus.esperar && !bus.puerta_abierta && m_t >= M + O) found = 1; end
    checks++; if (!found) begin errors++; $display("FAIL rmid_closing: got no CLOSING expected CLOSING within 20 cycles"); end
    cp0 = bus.cambio_piso;
    bus.estado = 4'b1000;
    cyc();
    bus.estado = 4'b0000;
    cp_changes = 0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.cambio_piso !== cp0) cp_changes++;
      if (!bus.esperar) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_finish: got esperar stuck expected door cycle to finish"); end
    checks++; if (cp_changes != 0) begin errors++; $display("FAIL rmid_no_toggle: got %0d cambio changes expected 0", cp_changes); end
  endtask

`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
  task automatic test_obstruct();
    int  pa_n, at_n;
    bit  found;
    bus.estado = 4'b0000;
    bus.s = 10'h040;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(); if (bus.puerta_abierta) found = 1; end
    bus.s = 10'h040;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin cyc(); if (bus.esperar && !bus.puerta_abierta) found = 1; end
    checks++; if (!found) begin errors++; $display("FAIL obs_closing: got no CLOSING expected CLOSING"); end
    bus.obstruccion = 1'b1;
    cyc();
    bus.obstruccion = 1'b0;
    pa_n = bus.puerta_abierta ? 1 : 0;
    at_n = (bus.atendido != '0) ? 1 : 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (bus.puerta_abierta) pa_n++;
      if (bus.atendido != '0) at_n++;
      if (!bus.esperar) found = 1;
    end
    checks++; if (pa_n != O) begin errors++; $display("FAIL obs_reopen: got %0d open cycles expected %0d", pa_n, O); end
    checks++; if (at_n != 0) begin errors++; $display("FAIL obs_no_repulse: got %0d pulses expected 0", at_n); end
    bus.s = '0;
    cyc();
  endtask
`endif

  task automatic test_random();
    int hold;
    reset = 1'b1;
    bus.s = '0;
    cyc();
    reset = 1'b0;
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        bus.estado = 4'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) bus.s = bus.s | (10'b1 << $urandom_range(0, 9));
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
      bus.obstruccion = ($urandom_range(0, 9) == 0);
`endif
      cyc();
      checks++; if (bus.cambio_piso !== m_cp) begin errors++; $display("FAIL rnd_cambio @%0d: got %b expected %b", i, bus.cambio_piso, m_cp); end
      checks++; if (bus.esperar !== m_esp) begin errors++; $display("FAIL rnd_esperar @%0d: got %b expected %b", i, bus.esperar, m_esp); end
      checks++; if (bus.puerta_abierta !== m_pa) begin errors++; $display("FAIL rnd_puerta @%0d: got %b expected %b", i, bus.puerta_abierta, m_pa); end
      checks++; if (bus.atendido !== m_at) begin errors++; $display("FAIL rnd_atendido @%0d: got %h expected %h", i, bus.atendido, m_at); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.estado = 4'b0000;
    bus.s = '0;
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    bus.obstruccion = 1'b0;
`endif
    test_reset();
    test_travel();
    test_door_up();
    test_door_down();
    test_idle_f1();
    test_reset_mid();
`ifdef ELEVATOR_DOOR_OBSTRUCT_EN
    test_obstruct();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
